serial_adder: RTL and testbench

Bit-serial adder: accepts two WIDTH-bit operands and a carry-in, and computes their sum LSB-first at one bit per clock. A single one-bit full-adder stage is reused every cycle, with the carry held in a flip-flop between cycles. It sits directly downstream of the team's combinational one-bit full adder. It is the sequential stage that consumes the adder's sum/carry outputs and assembles a multi-bit result, trading latency for area.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_adder_fa.sv | 18 +
 rtl/serial_adder.sv | 105 ++++++++++
 tb/tb_serial_adder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding shared by the bit-serial adder.
// Revision 1.0
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_adder_fa.sv
// serial_adder_fa: combinational one-bit full adder.
// Revision 1.0
`default_nettype none

module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one bit per clock through a single full adder.
// Revision 1.0
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  import serial_adder_pkg::*;

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic               load, finish;
  logic [WIDTH-1:0]   a_sh, b_sh;
  // Only the upper WIDTH-1 result bits are ever stored: bit 0 of a
  // conventional shift register would always be shifted out unread.
  logic [WIDTH-2:0]   sum_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               fa_sum, fa_carry;
  logic [WIDTH-1:0]   shift_val;

  serial_adder_fa u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign shift_val = {fa_sum, sum_sh};
  assign busy      = (state == RUN);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= finish;
      if (load) begin
        a_sh   <= a;
        b_sh   <= b;
        carry  <= cin;
        sum_sh <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        sum_sh <= shift_val[WIDTH-1:1];
        carry  <= fa_carry;
        cnt    <= cnt + CNT_W'(1);
      end
      // Outputs move only at completion so partial sums are never visible.
      if (finish) begin
        sum  <= shift_val;
        cout <= fa_carry;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8 plus exhaustive WIDTH=4 sweep.
// Revision 1.0
`default_nettype none

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] prev_s8;
  logic       prev_c8;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk (clk), .rst (rst), .start (start8), .a (a8), .b (b8), .cin (cin8),
    .busy (busy8), .done (done8), .sum (sum8), .cout (cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk (clk), .rst (rst), .start (start4), .a (a4), .b (b4), .cin (cin4),
    .busy (busy4), .done (done4), .sum (sum4), .cout (cout4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 addition; inj >= 0 pulses a conflicting start at that RUN sample.
  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                     input logic tc, input logic [7:0] es, input logic ec, input int inj);
    int         busy_cnt = 0;
    int         done_cnt = 0;
    int         done_idx = -1;
    logic       partial  = 1'b0;
    logic [7:0] got_s    = 8'h00;
    logic       got_c    = 1'b0;
    a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cnt++;
        done_idx = i;
        got_s    = sum8;
        got_c    = cout8;
      end else if (done_cnt == 0 && (sum8 !== prev_s8 || cout8 !== prev_c8)) begin
        partial = 1'b1;
      end
      if (i == inj) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      tick();
    end
    chk({tag, "_busy_cycles"}, busy_cnt, 8);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_done_edge"}, done_idx, 8);
    chk({tag, "_sum"}, got_s, es);
    chk({tag, "_cout"}, got_c, ec);
    chk({tag, "_no_partial"}, partial, 1'b0);
    prev_s8 = es;
    prev_c8 = ec;
  endtask

  initial begin
    int done_cnt;
    int last_idx;
    int k;
    int expv;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_done8", done8, 1'b0);
    chk("rst_sum8", sum8, 8'h00);
    chk("rst_cout8", cout8, 1'b0);
    chk("rst_busy4", busy4, 1'b0);
    chk("rst_sum4", {cout4, sum4}, 5'h00);
    prev_s8 = 8'h00;
    prev_c8 = 1'b0;

    op8("add_3c_42", 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, -1);
    op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
    op8("add_a5_5a_c", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, -1);
    op8("add_12_34_c", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, -1);
    // Conflicting start in RUN must be dropped: result unchanged, one done.
    op8("ignore_start", 8'h10, 8'h21, 1'b0, 8'h31, 1'b0, 3);

    // Reset four samples into RUN aborts the addition.
    a8 = 8'h80; b8 = 8'h81; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_sum", sum8, 8'h00);
    chk("abort_cout", cout8, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 || busy8) done_cnt++;
      tick();
    end
    chk("abort_no_done", done_cnt, 0);
    prev_s8 = 8'h00;
    prev_c8 = 1'b0;
    op8("after_abort", 8'h55, 8'h22, 1'b1, 8'h78, 1'b0, -1);

    // start held high: back-to-back results every 9 cycles.
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    done_cnt = 0;
    last_idx = -1;
    for (int i = 0; i < 30; i++) begin
      if (done8) begin
        done_cnt++;
        chk("b2b_sum", {cout8, sum8}, 9'h002);
        if (last_idx >= 0) chk("b2b_gap", i - last_idx, 9);
        else chk("b2b_first", i, 8);
        last_idx = i;
      end
      tick();
    end
    start8 = 1'b0;
    chk("b2b_count", done_cnt, 3);
    for (int i = 0; i < 12; i++) tick();

    // Exhaustive WIDTH=4 sweep, each start issued during the previous done cycle.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a4 = 4'(ia); b4 = 4'(ib); cin4 = ic[0]; start4 = 1'b1;
          tick();
          start4 = 1'b0;
          k = 0;
          while (!done4 && k < 10) begin
            tick();
            k++;
          end
          expv = ia + ib + ic;
          chk("w4_done", done4, 1'b1);
          chk($sformatf("w4_sum_%0d_%0d_%0d", ia, ib, ic), {cout4, sum4}, expv);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
